// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared definitions for data_mem_cache_param.
//   - sign_mask encodings (access size in [2:0], signed-load flag in [3])
//   - cache controller FSM state type
//   - store lane-merge and load extend helpers
package data_mem_pkg;

  localparam logic [2:0] SM_BYTE       = 3'b001;
  localparam logic [2:0] SM_HALF       = 3'b011;
  localparam logic [2:0] SM_WORD       = 3'b111;
  localparam int         SM_SIGNED_BIT = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    UPDATE    = 3'd4
  } state_t;

  // Merge right-aligned store data into the addressed lane(s) of a word.
  // Half stores ignore off[0]; unrecognised sizes behave as a full word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input logic [2:0]  size);
    logic [31:0] res;
    res = old_word;
    case (size)
      SM_BYTE: res[{off, 3'b000} +: 8]        = wdata[7:0];
      SM_HALF: res[{off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: res                            = wdata;
    endcase
    return res;
  endfunction

  // Pick the addressed lane(s) of a word and sign/zero extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [3:0]  sm);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (sm[2:0])
      SM_BYTE: res = {{24{sm[SM_SIGNED_BIT] & b[7]}}, b};
      SM_HALF: res = {{16{sm[SM_SIGNED_BIT] & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/backing_mem.sv
// backing_mem: single-port word RAM with a fixed multi-cycle access time.
//   clk, rst_n     : clock, async active-low reset (aborts an access in flight)
//   req, we        : start an access (accepted when idle or on the ready cycle)
//   addr, wdata    : word address and write data, captured with req
//   ready          : high for one cycle, MEM_LATENCY cycles after req is taken;
//                    a write commits and rdata is valid on that cycle
//   rdata          : read data of the captured address
// The storage array itself is never cleared.
module backing_mem #(
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 4,
  localparam int AW = $clog2(MEM_WORDS),
  localparam int CW = $clog2(MEM_LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic [31:0]   rdata
);

  logic [31:0]   mem_q [MEM_WORDS];
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ready_s;

  assign ready_s = busy_q && (cnt_q == CW'(MEM_LATENCY));
  assign ready   = ready_s;
  assign rdata   = mem_q[addr_q];

  // Next-state for the access counter; a new request may start on the ready cycle.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if (busy_q) begin
      if (ready_s) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (req && (!busy_q || ready_s)) begin
      busy_d  = 1'b1;
      cnt_d   = CW'(1);
      addr_d  = addr;
      we_d    = we;
      wdata_d = wdata;
    end else begin
      busy_d = busy_d;
    end
  end

  // Access control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage array, written when a write access completes.
  always_ff @(posedge clk) begin
    if (ready_s && we_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule

// File: rtl/data_mem_cache_param.sv
// data_mem_cache_param: direct-mapped, write-back, one-word-per-line data cache
// in front of backing_mem, with a memory-mapped LED register.
//   clk, rst_n          : clock, async active-low reset
//   addr                : byte address
//   write_data          : store data, right-aligned
//   memwrite, memread   : store / load request (both high = store)
//   sign_mask           : [3] signed load, [2:0] 001 byte / 011 half / 111 word
//   read_data           : extended load result, held between loads
//   led                 : LED register at LED_ADDR
//   clk_stall           : high while a cacheable access is in flight
// Optional (macro DATA_MEM_STATS_EN): hit_count, miss_count saturating counters.
module data_mem_cache_param
  import data_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          MEM_WORDS   = 1024,
  parameter int          NUM_LINES   = 16,
  parameter int          MEM_LATENCY = 4,
  parameter logic [31:0] LED_ADDR    = 32'h2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           write_data,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [3:0]            sign_mask,
  output logic [31:0]           read_data,
  output logic [7:0]            led,
`ifdef DATA_MEM_STATS_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  output logic                  clk_stall
);

  localparam int WORD_AW = $clog2(MEM_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_W   = WORD_AW - IDX_W;
  localparam logic [ADDR_WIDTH-1:0] LED_A = ADDR_WIDTH'(LED_ADDR);

  state_t               state_q, state_d;
  logic                 stall_q, stall_d;
  logic [31:0]          read_data_q, read_data_d;
  logic [7:0]           led_q, led_d;
  logic [WORD_AW-1:0]   req_word_q, req_word_d;
  logic [1:0]           req_off_q, req_off_d;
  logic                 req_we_q, req_we_d;
  logic [31:0]          req_wdata_q, req_wdata_d;
  logic [3:0]           req_sm_q, req_sm_d;
  logic [31:0]          fill_q, fill_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  logic [IDX_W-1:0]     req_idx_s;
  logic [TAG_W-1:0]     req_tag_s;
  logic                 hit_s;
  logic                 line_we_s;
  logic [31:0]          line_data_s;
  logic                 mem_req_s, mem_we_s, mem_ready_s;
  logic [WORD_AW-1:0]   mem_addr_s;
  logic [31:0]          mem_wdata_s, mem_rdata_s;

  assign req_idx_s = req_word_q[IDX_W-1:0];
  assign req_tag_s = req_word_q[WORD_AW-1:IDX_W];
  assign hit_s     = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign read_data = read_data_q;
  assign led       = led_q;
  assign clk_stall = stall_q;

  backing_mem #(
    .MEM_WORDS  (MEM_WORDS),
    .MEM_LATENCY(MEM_LATENCY)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (mem_req_s),
    .we   (mem_we_s),
    .addr (mem_addr_s),
    .wdata(mem_wdata_s),
    .ready(mem_ready_s),
    .rdata(mem_rdata_s)
  );

  // Controller next-state, memory requests and line updates.
  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    read_data_d = read_data_q;
    led_d       = led_q;
    req_word_d  = req_word_q;
    req_off_d   = req_off_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    req_sm_d    = req_sm_q;
    fill_d      = fill_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    line_we_s   = 1'b0;
    line_data_s = data_q[req_idx_s];
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = req_word_q;
    mem_wdata_s = data_q[req_idx_s];
    case (state_q)
      IDLE: begin
        if (memwrite || memread) begin
          if (addr == LED_A) begin
            // LED register is served at once, no stall.
            if (memwrite) begin
              led_d = write_data[7:0];
            end else begin
              read_data_d = {24'd0, led_q};
            end
          end else begin
            req_word_d  = addr[WORD_AW+1:2];
            req_off_d   = addr[1:0];
            req_we_d    = memwrite;
            req_wdata_d = write_data;
            req_sm_d    = sign_mask;
            stall_d     = 1'b1;
            state_d     = LOOKUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          if (req_we_q) begin
            line_we_s          = 1'b1;
            line_data_s        = lane_merge(data_q[req_idx_s], req_wdata_q, req_off_q, req_sm_q[2:0]);
            dirty_d[req_idx_s] = 1'b1;
          end else begin
            read_data_d = load_extend(data_q[req_idx_s], req_off_q, req_sm_q);
          end
          stall_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q[req_idx_s] && dirty_q[req_idx_s]) begin
          // Victim address is rebuilt from the stored tag and this index.
          mem_req_s  = 1'b1;
          mem_we_s   = 1'b1;
          mem_addr_s = {tag_q[req_idx_s], req_idx_s};
          state_d    = WRITEBACK;
        end else begin
          mem_req_s = 1'b1;
          state_d   = FILL;
        end
      end
      WRITEBACK: begin
        if (mem_ready_s) begin
          mem_req_s = 1'b1;
          state_d   = FILL;
        end else begin
          state_d = WRITEBACK;
        end
      end
      FILL: begin
        if (mem_ready_s) begin
          fill_d  = mem_rdata_s;
          state_d = UPDATE;
        end else begin
          state_d = FILL;
        end
      end
      UPDATE: begin
        line_we_s          = 1'b1;
        valid_d[req_idx_s] = 1'b1;
        if (req_we_q) begin
          line_data_s        = lane_merge(fill_q, req_wdata_q, req_off_q, req_sm_q[2:0]);
          dirty_d[req_idx_s] = 1'b1;
        end else begin
          line_data_s        = fill_q;
          dirty_d[req_idx_s] = 1'b0;
          read_data_d        = load_extend(fill_q, req_off_q, req_sm_q);
        end
        stall_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Controller and line-status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      read_data_q <= 32'd0;
      led_q       <= 8'd0;
      req_word_q  <= '0;
      req_off_q   <= 2'd0;
      req_we_q    <= 1'b0;
      req_wdata_q <= 32'd0;
      req_sm_q    <= 4'd0;
      fill_q      <= 32'd0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      read_data_q <= read_data_d;
      led_q       <= led_d;
      req_word_q  <= req_word_d;
      req_off_q   <= req_off_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      req_sm_q    <= req_sm_d;
      fill_q      <= fill_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Tag and data arrays; contents survive reset, only valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      tag_q[req_idx_s]  <= req_tag_s;
      data_q[req_idx_s] <= line_data_s;
    end
  end

`ifdef DATA_MEM_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // One hit or miss is counted as each access leaves LOOKUP, saturating.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP) begin
      if (hit_s) begin
        hit_cnt_d = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
      end
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif

endmodule
